// File: rtl/axis_user_tagger_pkg.sv
// Shared definitions for the AXI4-Stream user tag injector: packet FSM
// encodings and a constant clog2 used to size the tag queue level.
package axis_user_tagger_pkg;

  typedef enum logic {
    ST_FIRST = 1'b0,  // next accepted beat starts a packet
    ST_BODY  = 1'b1   // inside a packet, beats reuse the bound tag
  } tag_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_user_tagger_fifo.sv
// First-word-fall-through tag FIFO. Level and flags are registered, so a
// pushed entry becomes visible (and poppable) the cycle after the push.
// A push while full is accepted only when a pop happens in the same cycle.
module user_tag_fifo
  import axis_user_tagger_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, level and registered full/empty flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10: begin
          level <= level + LW'(1);
          empty <= 1'b0;
          full  <= (level == LW'(DEPTH - 1));
        end
        2'b01: begin
          level <= level - LW'(1);
          full  <= 1'b0;
          empty <= (level == LW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_user_tagger.sv
// AXI4-Stream user tag injector. Queued tags are bound one per packet at the
// first beat and driven on m0_tuser for every beat of that packet through a
// single registered output stage.
//
// Handshake: a beat transfers on a port in a cycle where tvalid and tready are
// both high at the rising edge; a source holds tvalid/tdata/tlast/tuser stable
// until that transfer, and tready may depend combinationally on tvalid state.
module axis_user_tagger
  import axis_user_tagger_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int USER_WIDTH     = 4,
  parameter  int QUEUE_DEPTH    = 4,
  parameter  int STALL_ON_EMPTY = 0,
  parameter  int RESET_USER     = 0,
  parameter  int COUNT_WIDTH    = 16,
  localparam int LEVEL_WIDTH    = clog2(QUEUE_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [USER_WIDTH-1:0]  next_user,
  input  logic                   next_user_write_enable,
  output logic [LEVEL_WIDTH-1:0] queue_level,
  output logic                   queue_full,
  output logic                   queue_empty,
  output logic                   overflow,
  input  logic                   overflow_clear,
  output logic [COUNT_WIDTH-1:0] packet_count,
  output logic                   s0_tready,
  input  logic                   s0_tvalid,
  input  logic [DATA_WIDTH-1:0]  s0_tdata,
  input  logic                   s0_tlast,
  input  logic                   m0_tready,
  output logic                   m0_tvalid,
  output logic [DATA_WIDTH-1:0]  m0_tdata,
  output logic                   m0_tlast,
  output logic [USER_WIDTH-1:0]  m0_tuser,
  output tag_state_e             state_dbg
);

  localparam bit                    STALL   = (STALL_ON_EMPTY != 0);
  localparam logic [USER_WIDTH-1:0] RST_TAG = USER_WIDTH'(RESET_USER);

  tag_state_e            state;
  tag_state_e            state_next;
  logic [USER_WIDTH-1:0] last_tag;
  logic [USER_WIDTH-1:0] cur_tag;
  logic [USER_WIDTH-1:0] head_tag;
  logic [USER_WIDTH-1:0] beat_tag;
  logic                  accept;
  logic                  pop;
  logic                  drop;

  assign state_dbg = state;

  // Upstream may advance when the output register is free or draining; in
  // stall mode a packet may not start until a tag is available.
  assign s0_tready = (~m0_tvalid | m0_tready) &
                     ~(STALL & (state == ST_FIRST) & queue_empty);
  assign accept    = s0_tvalid & s0_tready;
  assign pop       = accept & (state == ST_FIRST) & ~queue_empty;
  assign drop      = next_user_write_enable & queue_full & ~pop;

  user_tag_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (USER_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (next_user_write_enable),
    .push_data (next_user),
    .pop       (pop),
    .pop_data  (head_tag),
    .level     (queue_level),
    .full      (queue_full),
    .empty     (queue_empty)
  );

  // Next-state and per-beat tag selection.
  always_comb begin
    state_next = state;
    beat_tag   = cur_tag;
    case (state)
      ST_FIRST: begin
        beat_tag = queue_empty ? last_tag : head_tag;
        if (accept) state_next = s0_tlast ? ST_FIRST : ST_BODY;
      end
      ST_BODY: begin
        if (accept && s0_tlast) state_next = ST_FIRST;
      end
      default: state_next = ST_FIRST;
    endcase
  end

  // Packet FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FIRST;
    else       state <= state_next;
  end

  // Bind the tag at the first beat; last_tag feeds the empty-queue reuse path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_tag <= RST_TAG;
      cur_tag  <= RST_TAG;
    end else if (accept && (state == ST_FIRST)) begin
      last_tag <= beat_tag;
      cur_tag  <= beat_tag;
    end
  end

  // Output register stage; payload only changes when a new beat is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_tvalid <= 1'b0;
      m0_tdata  <= '0;
      m0_tlast  <= 1'b0;
      m0_tuser  <= RST_TAG;
    end else if (accept) begin
      m0_tvalid <= 1'b1;
      m0_tdata  <= s0_tdata;
      m0_tlast  <= s0_tlast;
      m0_tuser  <= beat_tag;
    end else if (m0_tready) begin
      m0_tvalid <= 1'b0;
    end
  end

  // Sticky overflow; a same-cycle drop wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (overflow_clear) overflow <= 1'b0;
  end

  // Completed packets leaving m0, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                packet_count <= '0;
    else if (m0_tvalid && m0_tready && m0_tlast) packet_count <= packet_count + COUNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_axis_user_tagger.sv
// Bench for axis_user_tagger: directed vector table, back-to-back and random
// backpressure traffic against a scoreboard, mid-packet reset, stall mode.
module tb_axis_user_tagger;
  import axis_user_tagger_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance: sticky mode, RESET_USER=6, 5-bit packet counter
  logic [3:0]  next_user = '0;
  logic        next_user_write_enable = 1'b0;
  logic [2:0]  queue_level;
  logic        queue_full, queue_empty, overflow;
  logic        overflow_clear = 1'b0;
  logic [4:0]  packet_count;
  logic        s0_tready;
  logic        s0_tvalid = 1'b0;
  logic [31:0] s0_tdata = '0;
  logic        s0_tlast = 1'b0;
  logic        m0_tready = 1'b1;
  logic        m0_tvalid;
  logic [31:0] m0_tdata;
  logic        m0_tlast;
  logic [3:0]  m0_tuser;
  tag_state_e  state_dbg;

  axis_user_tagger #(
    .DATA_WIDTH(32), .USER_WIDTH(4), .QUEUE_DEPTH(4), .STALL_ON_EMPTY(0),
    .RESET_USER(6), .COUNT_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .next_user(next_user),
    .next_user_write_enable(next_user_write_enable), .queue_level(queue_level),
    .queue_full(queue_full), .queue_empty(queue_empty), .overflow(overflow),
    .overflow_clear(overflow_clear), .packet_count(packet_count),
    .s0_tready(s0_tready), .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata),
    .s0_tlast(s0_tlast), .m0_tready(m0_tready), .m0_tvalid(m0_tvalid),
    .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tuser(m0_tuser),
    .state_dbg(state_dbg)
  );

  // stall-mode instance
  logic [3:0]  t_next_user = '0;
  logic        t_nuw = 1'b0;
  logic [2:0]  t_queue_level;
  logic        t_queue_full, t_queue_empty, t_overflow;
  logic        t_clr = 1'b0;
  logic [15:0] t_packet_count;
  logic        t_s0_tready;
  logic        t_s0_tvalid = 1'b0;
  logic [31:0] t_s0_tdata = '0;
  logic        t_s0_tlast = 1'b0;
  logic        t_m0_tready = 1'b1;
  logic        t_m0_tvalid;
  logic [31:0] t_m0_tdata;
  logic        t_m0_tlast;
  logic [3:0]  t_m0_tuser;
  tag_state_e  t_state_dbg;

  axis_user_tagger #(
    .DATA_WIDTH(32), .USER_WIDTH(4), .QUEUE_DEPTH(4), .STALL_ON_EMPTY(1),
    .RESET_USER(0), .COUNT_WIDTH(16)
  ) dut_stall (
    .clk(clk), .reset(reset), .next_user(t_next_user),
    .next_user_write_enable(t_nuw), .queue_level(t_queue_level),
    .queue_full(t_queue_full), .queue_empty(t_queue_empty), .overflow(t_overflow),
    .overflow_clear(t_clr), .packet_count(t_packet_count),
    .s0_tready(t_s0_tready), .s0_tvalid(t_s0_tvalid), .s0_tdata(t_s0_tdata),
    .s0_tlast(t_s0_tlast), .m0_tready(t_m0_tready), .m0_tvalid(t_m0_tvalid),
    .m0_tdata(t_m0_tdata), .m0_tlast(t_m0_tlast), .m0_tuser(t_m0_tuser),
    .state_dbg(t_state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [36:0] exp_q[$];   // {tlast, tuser, tdata}
  logic [3:0]  tq[$];      // model of the tag queue
  logic [3:0]  last_tag_m = 4'd6;
  logic [3:0]  cur_tag_m  = 4'd6;
  bit          in_pkt_m   = 1'b0;
  int          pkt_m      = 0;
  bit          mon_en     = 1'b0;

  // One cycle of stimulus on the main instance; updates the model for
  // whatever the rising edge will do with these inputs.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit push,
                      input logic [3:0] tag, input bit clr, input bit rdy, output bit acc);
    logic [3:0] t;
    @(negedge clk);
    s0_tvalid = v; s0_tdata = d; s0_tlast = l;
    next_user_write_enable = push; next_user = tag;
    overflow_clear = clr; m0_tready = rdy;
    #1;
    acc = v && s0_tready;
    if (acc) begin
      if (!in_pkt_m) begin
        if (tq.size() > 0) t = tq.pop_front();
        else               t = last_tag_m;
        last_tag_m = t;
        cur_tag_m  = t;
      end else begin
        t = cur_tag_m;
      end
      in_pkt_m = !l;
      if (l) pkt_m++;
      exp_q.push_back({l, t, d});
    end
    if (push && tq.size() < 4) tq.push_back(tag);
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, a);
  endtask

  // Output monitor: compares every m0 transfer against the expected queue
  // and checks the payload stays frozen while stalled.
  bit          hold_prev = 1'b0;
  logic [36:0] prev_beat;
  always begin
    @(negedge clk);
    #1;
    if (!mon_en) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("m0_hold_valid", 64'(m0_tvalid), 64'd1);
        check("m0_hold_payload", 64'({m0_tlast, m0_tuser, m0_tdata}), 64'(prev_beat));
      end
      if (m0_tvalid && m0_tready) begin
        if (exp_q.size() == 0) check("m0_unexpected_beat", 64'(m0_tdata), 64'hDEAD);
        else check("m0_beat", 64'({m0_tlast, m0_tuser, m0_tdata}), 64'(exp_q.pop_front()));
      end
      hold_prev = m0_tvalid && !m0_tready;
      prev_beat = {m0_tlast, m0_tuser, m0_tdata};
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          l;
    bit          push;
    logic [3:0]  tag;
    bit          clr;
    logic [3:0]  ut;    // expected m0_tuser of this beat
    logic [2:0]  lvl;   // expected queue_level after the cycle
    bit          ovf;   // expected overflow after the cycle
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [31:0] d, bit l, bit push, logic [3:0] tag,
                              bit clr, logic [3:0] ut, logic [2:0] lvl, bit ovf);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.push = push; r.tag = tag;
    r.clr = clr; r.ut = ut; r.lvl = lvl; r.ovf = ovf;
    return r;
  endfunction

  // ---------------- stall-instance driver ----------------
  task automatic st_drive(input bit v, input logic [31:0] d, input bit l,
                          input bit push, input logic [3:0] tag);
    @(negedge clk);
    t_s0_tvalid = v; t_s0_tdata = d; t_s0_tlast = l;
    t_nuw = push; t_next_user = tag; t_m0_tready = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries;
    int len;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_tvalid", 64'(m0_tvalid), 64'd0);
    check("rst_m0_tdata", 64'(m0_tdata), 64'd0);
    check("rst_m0_tlast", 64'(m0_tlast), 64'd0);
    check("rst_m0_tuser", 64'(m0_tuser), 64'd6);
    check("rst_level", 64'(queue_level), 64'd0);
    check("rst_empty", 64'(queue_empty), 64'd1);
    check("rst_full", 64'(queue_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_packet_count", 64'(packet_count), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_FIRST));
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // ---- table: tags 3,7 -> packets of 4,1,2 beats ----
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd3, 0, 4'd0, 3'd1, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd7, 0, 4'd0, 3'd2, 0));
    tbl.push_back(mk(1, 32'hA0, 0, 0, 4'd0, 0, 4'd3, 3'd1, 0));
    tbl.push_back(mk(1, 32'hA1, 0, 0, 4'd0, 0, 4'd3, 3'd1, 0));
    tbl.push_back(mk(1, 32'hA2, 0, 0, 4'd0, 0, 4'd3, 3'd1, 0));
    tbl.push_back(mk(1, 32'hA3, 1, 0, 4'd0, 0, 4'd3, 3'd1, 0));
    tbl.push_back(mk(1, 32'hB0, 1, 0, 4'd0, 0, 4'd7, 3'd0, 0));
    tbl.push_back(mk(1, 32'hC0, 0, 0, 4'd0, 0, 4'd7, 3'd0, 0));
    tbl.push_back(mk(1, 32'hC1, 1, 0, 4'd0, 0, 4'd7, 3'd0, 0));
    // fill 1,2,3,4 then 9 is dropped -> overflow
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd1, 0, 4'd0, 3'd1, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd2, 0, 4'd0, 3'd2, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd3, 0, 4'd0, 3'd3, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd4, 0, 4'd0, 3'd4, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd9, 0, 4'd0, 3'd4, 1));
    tbl.push_back(mk(1, 32'hD1, 1, 0, 4'd0, 0, 4'd1, 3'd3, 1));
    tbl.push_back(mk(1, 32'hD2, 1, 0, 4'd0, 0, 4'd2, 3'd2, 1));
    tbl.push_back(mk(1, 32'hD3, 1, 0, 4'd0, 0, 4'd3, 3'd1, 1));
    tbl.push_back(mk(1, 32'hD4, 1, 0, 4'd0, 0, 4'd4, 3'd0, 1));
    tbl.push_back(mk(0, 32'h0,  0, 0, 4'd0, 1, 4'd0, 3'd0, 0));
    // full queue + push together with a first-beat pop
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd5, 0, 4'd0, 3'd1, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd6, 0, 4'd0, 3'd2, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd7, 0, 4'd0, 3'd3, 0));
    tbl.push_back(mk(0, 32'h0,  0, 1, 4'd8, 0, 4'd0, 3'd4, 0));
    tbl.push_back(mk(1, 32'hE0, 0, 1, 4'd10, 0, 4'd5, 3'd4, 0));
    tbl.push_back(mk(1, 32'hE1, 1, 0, 4'd0, 0, 4'd5, 3'd4, 0));
    tbl.push_back(mk(1, 32'hF0, 1, 0, 4'd0, 0, 4'd6, 3'd3, 0));
    tbl.push_back(mk(1, 32'hF1, 1, 0, 4'd0, 0, 4'd7, 3'd2, 0));
    tbl.push_back(mk(1, 32'hF2, 1, 0, 4'd0, 0, 4'd8, 3'd1, 0));
    tbl.push_back(mk(1, 32'hF3, 1, 0, 4'd0, 0, 4'd10, 3'd0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].push, tbl[i].tag, tbl[i].clr, 1'b1, acc);
      if (tbl[i].v) check($sformatf("tbl%0d_accept", i), 64'(acc), 64'd1);
      idle();
      check($sformatf("tbl%0d_level", i), 64'(queue_level), 64'(tbl[i].lvl));
      check($sformatf("tbl%0d_full", i), 64'(queue_full), 64'(tbl[i].lvl == 3'd4));
      check($sformatf("tbl%0d_empty", i), 64'(queue_empty), 64'(tbl[i].lvl == 3'd0));
      check($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(tbl[i].ovf));
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_m0_tvalid", i), 64'(m0_tvalid), 64'd1);
        check($sformatf("tbl%0d_m0_tuser", i), 64'(m0_tuser), 64'(tbl[i].ut));
        check($sformatf("tbl%0d_m0_tdata", i), 64'(m0_tdata), 64'(tbl[i].d));
      end
    end
    idle();
    check("tbl_packet_count", 64'(packet_count), 64'd12);

    // ---- back-to-back 8-beat packet: one beat per cycle ----
    for (int b = 0; b < 8; b++) begin
      step(1'b1, 32'h100 + 32'(b), b == 7, 1'b0, 4'd0, 1'b0, 1'b1, acc);
      check($sformatf("b2b_accept%0d", b), 64'(acc), 64'd1);
    end
    idle();
    idle();

    // ---- random backpressure, 100 packets of 1..16 beats ----
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 16);
      for (int b = 0; b < len; b++) begin
        bit v;
        tries = 0;
        do begin
          bit push;
          v    = ($urandom_range(0, 4) != 0);
          push = (tq.size() < 4) && ($urandom_range(0, 3) == 0);
          step(v, {16'(p), 16'(b)}, b == len - 1, push, 4'($urandom_range(0, 15)),
               1'b0, $urandom_range(0, 2) != 0, acc);
          tries++;
        end while (!(v && acc) && tries < 200);
        if (tries >= 200) check("rand_accept_timeout", 64'(tries), 64'd0);
      end
    end
    tries = 0;
    while (exp_q.size() > 0 && tries < 100) begin
      idle();
      tries++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_packet_count", 64'(packet_count), 64'(pkt_m % 32));

    // ---- reset during beat 2 of a 5-beat packet with 2 tags queued ----
    tries = 0;
    while (tq.size() > 0 && tries < 8) begin
      step(1'b1, 32'h77, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, acc);
      tries++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd11, 1'b0, 1'b1, acc);
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b1, acc);
    step(1'b1, 32'h501, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, acc);
    step(1'b1, 32'h502, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, acc);
    @(negedge clk);
    mon_en = 1'b0;
    s0_tvalid = 1'b0; next_user_write_enable = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_m0_tvalid", 64'(m0_tvalid), 64'd0);
    check("midrst_level", 64'(queue_level), 64'd0);
    check("midrst_empty", 64'(queue_empty), 64'd1);
    check("midrst_m0_tuser", 64'(m0_tuser), 64'd6);
    check("midrst_m0_tdata", 64'(m0_tdata), 64'd0);
    check("midrst_packet_count", 64'(packet_count), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(ST_FIRST));
    exp_q.delete();
    tq.delete();
    last_tag_m = 4'd6; cur_tag_m = 4'd6; in_pkt_m = 1'b0; pkt_m = 0;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    step(1'b1, 32'h600, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, acc);
    check("postrst_accept", 64'(acc), 64'd1);
    idle();
    check("postrst_m0_tvalid", 64'(m0_tvalid), 64'd1);
    check("postrst_m0_tuser", 64'(m0_tuser), 64'd6);
    check("postrst_m0_tdata", 64'(m0_tdata), 64'h600);
    idle();
    check("postrst_packet_count", 64'(packet_count), 64'd1);

    // ---- stall mode: empty queue blocks packet start ----
    for (int k = 0; k < 3; k++) begin
      st_drive(1'b1, 32'hC000, 1'b0, 1'b0, 4'd0);
      check($sformatf("stall_ready_wait%0d", k), 64'(t_s0_tready), 64'd0);
    end
    st_drive(1'b1, 32'hC000, 1'b0, 1'b1, 4'd5);           // cycle N: push 5
    check("stall_ready_at_push", 64'(t_s0_tready), 64'd0);
    st_drive(1'b1, 32'hC000, 1'b0, 1'b0, 4'd0);           // N+1: accept beat 0
    check("stall_ready_after_push", 64'(t_s0_tready), 64'd1);
    check("stall_level_after_push", 64'(t_queue_level), 64'd1);
    st_drive(1'b1, 32'hC001, 1'b0, 1'b0, 4'd0);
    check("stall_b0_valid", 64'(t_m0_tvalid), 64'd1);
    check("stall_b0_data", 64'(t_m0_tdata), 64'hC000);
    check("stall_b0_user", 64'(t_m0_tuser), 64'd5);
    check("stall_level_after_pop", 64'(t_queue_level), 64'd0);
    check("stall_body_ready", 64'(t_s0_tready), 64'd1);
    st_drive(1'b1, 32'hC002, 1'b1, 1'b0, 4'd0);
    check("stall_b1_data", 64'(t_m0_tdata), 64'hC001);
    check("stall_b1_user", 64'(t_m0_tuser), 64'd5);
    st_drive(1'b1, 32'hC003, 1'b1, 1'b0, 4'd0);
    check("stall_b2_data", 64'(t_m0_tdata), 64'hC002);
    check("stall_b2_last", 64'(t_m0_tlast), 64'd1);
    check("stall_b2_user", 64'(t_m0_tuser), 64'd5);
    check("stall_next_pkt_blocked", 64'(t_s0_tready), 64'd0);
    st_drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    check("stall_packet_count", 64'(t_packet_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_user_tagger.md
# axis_user_tagger

Parametrised AXI4-Stream tag injector. It sits in the ADC/DAC streaming path between a stream source and a DMA or packet consumer. Software (or control logic) queues up to QUEUE_DEPTH user tags; each tag is bound to exactly one packet at its first beat and driven on m0_tuser for every beat of that packet. The data path is a single registered stage that sustains full throughput. An empty queue either reuses the previous tag or stalls the packet start, selected by parameter.

## Interface
- DATA_WIDTH, 32, tdata width
- USER_WIDTH, 4, tag / tuser width
- QUEUE_DEPTH, 4, tag FIFO entries; power of two, ≥2
- STALL_ON_EMPTY, 0, 0 = reuse last tag when queue empty; 1 = hold s0_tready low at packet start until queue non-empty
- RESET_USER, 0, initial value of last-tag register
- COUNT_WIDTH, 16, packet counter width
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- next_user  in  USER_WIDTH  tag to enqueue
- next_user_write_enable  in  1  enqueue strobe, one tag per cycle
- queue_level  out  clog2(QUEUE_DEPTH)+1  entries held
- queue_full / queue_empty  out  1  level flags
- overflow  out  1  sticky: enqueue dropped while full
- overflow_clear  in  1  clears overflow
- packet_count  out  COUNT_WIDTH  packets completed at m0, wraps
- s0_tready  out  1 / s0_tvalid  in  1 / s0_tdata  in  DATA_WIDTH / s0_tlast  in  1
- m0_tready  in  1 / m0_tvalid  out  1 / m0_tdata  out  DATA_WIDTH / m0_tlast  out  1 / m0_tuser  out  USER_WIDTH

## Operation
- States: FIRST (next accepted beat starts a packet), BODY. Reset → FIRST.
- Accept = s0_tvalid & s0_tready.
- FIRST + accept: tag = queue head if queue non-empty (pop), else last_tag. last_tag ← tag, cur_tag ← tag. Next state: BODY if s0_tlast=0, else FIRST (1-beat packet).
- BODY + accept: beat carries cur_tag; s0_tlast=1 → FIRST.
- s0_tready = (~m0_tvalid | m0_tready) & ~(STALL_ON_EMPTY & state==FIRST & queue_empty).
- Enqueue when not full: write next_user; level+1.
- Enqueue when full and no pop in the same cycle: drop, set overflow. Enqueue when full with a simultaneous pop: accepted, level unchanged.
- Simultaneous push and pop on a non-full queue: level unchanged.
- No bypass: a tag pushed in cycle N cannot be popped before cycle N+1.
- overflow_clear has priority below a same-cycle set. A set wins.
- packet_count increments on m0_tvalid & m0_tready & m0_tlast, wrapping from 2^COUNT_WIDTH−1 to 0.
- Packet boundaries and tdata are passed unmodified. Beats are never dropped or reordered.

## Timing
- Reset values: m0_tvalid=0, m0_tdata=0, m0_tlast=0, m0_tuser=RESET_USER, queue_level=0, queue_empty=1, queue_full=0, overflow=0, packet_count=0, state FIRST, last_tag=RESET_USER.
- Latency: a beat accepted in cycle N appears on m0 in cycle N+1 with its tag.
- m0 holds data, last and user stable while m0_tvalid & ~m0_tready.
- Throughput: 1 beat/cycle when m0_tready is held high.
- Stall mode with the queue empty at FIRST: s0_tready=0 for as long as the queue is empty. The first push in cycle N allows acceptance from cycle N+1.
- queue flags and level are registered and update the cycle after push/pop.
- Reset asserted mid-packet: all outputs return to reset values immediately. The partial packet is abandoned and the next accepted beat is treated as a first beat.

## Structure
- Shared package/include: state encodings (FIRST, BODY) and a clog2 constant function used for queue_level sizing.
- Sub-module user_tag_fifo: QUEUE_DEPTH × USER_WIDTH synchronous FIFO, first-word-fall-through, with push, pop, level, full and empty. Same async active-high reset.
- Top level contains the output register stage, the FSM, last_tag/cur_tag registers, the overflow flag and packet_count.

## Test plan
- Sticky mode, push tags 3, 7; send packets of 4, 1 and 2 beats with m0_tready=1 → m0_tuser 3,3,3,3 / 7 / 7,7. Final queue_level=0, packet_count=3.
- Stall mode, queue empty, s0_tvalid high with a 3-beat packet → s0_tready=0. Push 5 in cycle N → first beat accepted in N+1; all 3 beats have tuser=5.
- QUEUE_DEPTH=4: push 1,2,3,4,9 with no traffic → queue_full=1, overflow=1, level=4. Four 1-beat packets carry 1,2,3,4. overflow_clear → overflow=0.
- Queue full with a push in the same cycle as a first-beat pop → level stays 4 and overflow stays 0.
- Random m0_tready backpressure on 100 packets with random lengths 1–16 → data, tlast and order are identical to the input, tuser is constant within each packet and matches the expected tag sequence, and m0 is stable under stall.
- Assert reset during beat 2 of a 5-beat packet with 2 tags queued → m0_tvalid=0, level=0, m0_tuser=RESET_USER. After release, a new packet's first beat uses last_tag=RESET_USER.
